// File: rtl/m_ext_issue_queue_if.sv
// Issue-side and mul/div-side signal bundle of the M-extension issue queue.
interface m_ext_issue_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic [TAG_W-1:0] illegal_tag;
    logic             mul_valid;
    logic             mul_ready;
    logic             div_valid;
    logic             div_ready;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic             signed_a;
    logic             signed_b;
    logic             upper_rem;
    logic             word;
    logic [TAG_W-1:0] head_tag;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, instr, rs1, rs2, tag, mul_ready, div_ready,
        output in_ready, illegal, illegal_tag, mul_valid, div_valid,
               op_a, op_b, signed_a, signed_b, upper_rem, word, head_tag, count
    );

    modport master (
        output in_valid, instr, rs1, rs2, tag, mul_ready, div_ready,
        input  in_ready, illegal, illegal_tag, mul_valid, div_valid,
               op_a, op_b, signed_a, signed_b, upper_rem, word, head_tag, count
    );
endinterface

// File: rtl/m_ext_issue_queue.sv
// RV32M/RV64M decode + in-order FIFO feeding mul/div ports; accepted op reaches head next cycle.
// Backpressure: in_ready is registered (count < DEPTH) and never depends on mul/div ready.
module m_ext_issue_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    m_ext_issue_queue_if.slave q
);
    localparam int  CW   = $clog2(DEPTH + 1);
    localparam int  PW   = $clog2(DEPTH);
    localparam bit  W_EN = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic             sa;
        logic             sb;
        logic             ur;
        logic             word;
        logic             div;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          entry_in;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            in_ready;
    logic            illegal;
    logic [TAG_W-1:0] illegal_tag;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_w;
    logic            w_ok;
    logic            legal;
    logic            sa;
    logic            sb;
    logic            ur;
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;

    logic            accept;
    logic            push;
    logic            pop;
    logic            nonempty;
    logic            mul_valid;
    logic            div_valid;
    logic            unused_instr;

    assign opcode = q.instr[6:0];
    assign funct3 = q.instr[14:12];
    assign funct7 = q.instr[31:25];
    // Register fields are irrelevant here: operands arrive already read.
    assign unused_instr = ^q.instr[24:15] ^ ^q.instr[11:7];

    always_comb begin
        is_w  = (opcode == 7'b0111011);
        w_ok  = funct3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        legal = (funct7 == 7'b0000001) &&
                ((opcode == 7'b0110011) || (W_EN && is_w && w_ok));
        sa    = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        sb    = funct3 inside {3'b001, 3'b100, 3'b110};
        ur    = funct3 inside {3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    end

    // W-ops operate on the low word; extension follows the operand's signedness.
    generate
        if (XLEN == 64) begin : g_word_ext
            assign a_in = is_w ? {{32{sa & q.rs1[31]}}, q.rs1[31:0]} : q.rs1;
            assign b_in = is_w ? {{32{sb & q.rs2[31]}}, q.rs2[31:0]} : q.rs2;
        end else begin : g_no_ext
            assign a_in = q.rs1;
            assign b_in = q.rs2;
        end
    endgenerate

    always_comb begin
        entry_in      = '0;
        entry_in.a    = a_in;
        entry_in.b    = b_in;
        entry_in.sa   = sa;
        entry_in.sb   = sb;
        entry_in.ur   = ur;
        entry_in.word = is_w;
        entry_in.div  = funct3[2];
        entry_in.tag  = q.tag;
    end

    assign head      = mem[rd_ptr];
    assign nonempty  = (count != '0);
    assign mul_valid = nonempty && !head.div;
    assign div_valid = nonempty &&  head.div;
    assign pop       = (mul_valid && q.mul_ready) || (div_valid && q.div_ready);
    assign accept    = q.in_valid && in_ready && !flush;
    assign push      = accept && legal;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            illegal     <= 1'b0;
            illegal_tag <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt < CW'(DEPTH));
            illegal  <= accept && !legal;
            if (accept && !legal) begin
                illegal_tag <= q.tag;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Head data is forced to zero when empty so stale or uninitialised slots never leak.
    always_comb begin
        q.in_ready    = in_ready;
        q.illegal     = illegal;
        q.illegal_tag = illegal_tag;
        q.count       = count;
        q.mul_valid   = mul_valid;
        q.div_valid   = div_valid;
        q.op_a        = '0;
        q.op_b        = '0;
        q.signed_a    = 1'b0;
        q.signed_b    = 1'b0;
        q.upper_rem   = 1'b0;
        q.word        = 1'b0;
        q.head_tag    = '0;
        if (nonempty) begin
            q.op_a      = head.a;
            q.op_b      = head.b;
            q.signed_a  = head.sa;
            q.signed_b  = head.sb;
            q.upper_rem = head.ur;
            q.word      = head.word;
            q.head_tag  = head.tag;
        end
    end
endmodule

// File: tb/tb_m_ext_issue_queue.sv
module tb_m_ext_issue_queue;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    m_ext_issue_queue_if #(.XLEN(32), .DEPTH(2), .TAG_W(4)) i32 ();
    m_ext_issue_queue_if #(.XLEN(64), .DEPTH(2), .TAG_W(4)) i64 ();

    m_ext_issue_queue #(.XLEN(32), .DEPTH(2), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .q(i32)
    );
    m_ext_issue_queue #(.XLEN(64), .DEPTH(2), .TAG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .q(i64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd0, opc};
    endfunction

    // {signed_a, signed_b, upper_rem, mul_valid, div_valid} per funct3
    logic [4:0] exp3 [8];

    initial begin
        exp3 = '{5'b00010, 5'b11110, 5'b10110, 5'b00110,
                 5'b11001, 5'b00001, 5'b11101, 5'b00101};
        rst_n = 1'b0;
        flush = 1'b0;
        i32.in_valid = 0; i32.instr = '0; i32.rs1 = '0; i32.rs2 = '0; i32.tag = '0;
        i32.mul_ready = 0; i32.div_ready = 0;
        i64.in_valid = 0; i64.instr = '0; i64.rs1 = '0; i64.rs2 = '0; i64.tag = '0;
        i64.mul_ready = 0; i64.div_ready = 0;
        step();
        step();
        chk("rst_count", 64'(i32.count), 0);
        chk("rst_in_ready", 64'(i32.in_ready), 0);
        chk("rst_valids", {62'd0, i32.mul_valid, i32.div_valid}, 0);
        chk("rst_illegal", 64'(i32.illegal), 0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 64'(i32.in_ready), 1);
        chk("rel_in_ready64", 64'(i64.in_ready), 1);

        // 1: single MUL
        i32.in_valid = 1; i32.instr = 32'h02208033; i32.rs1 = 7; i32.rs2 = 6; i32.tag = 3;
        step();
        i32.in_valid = 0;
        chk("t1_mul_valid", 64'(i32.mul_valid), 1);
        chk("t1_div_valid", 64'(i32.div_valid), 0);
        chk("t1_op_a", 64'(i32.op_a), 7);
        chk("t1_op_b", 64'(i32.op_b), 6);
        chk("t1_flags", {60'd0, i32.signed_a, i32.signed_b, i32.upper_rem, i32.word}, 0);
        chk("t1_tag", 64'(i32.head_tag), 3);
        chk("t1_count", 64'(i32.count), 1);
        i32.mul_ready = 1;
        step();
        chk("t1_drained", 64'(i32.count), 0);
        chk("t1_mul_low", 64'(i32.mul_valid), 0);
        i32.mul_ready = 0;

        // 2: W-op at XLEN=32 and bad funct7 are both illegal
        i32.in_valid = 1; i32.instr = mk(7'b0000001, 3'b000, 7'b0111011); i32.tag = 5;
        step();
        chk("t2_ill1", 64'(i32.illegal), 1);
        chk("t2_ill1_tag", 64'(i32.illegal_tag), 5);
        chk("t2_ill1_count", 64'(i32.count), 0);
        i32.instr = mk(7'b0100001, 3'b000, 7'b0110011); i32.tag = 9;
        step();
        i32.in_valid = 0;
        chk("t2_ill2", 64'(i32.illegal), 1);
        chk("t2_ill2_tag", 64'(i32.illegal_tag), 9);
        chk("t2_ill2_valids", {61'd0, i32.count, i32.mul_valid, i32.div_valid}, 0);
        step();
        chk("t2_ill_pulse_end", 64'(i32.illegal), 0);

        // 3: funct3 sweep through a streaming queue
        i32.mul_ready = 1; i32.div_ready = 1;
        for (int f = 0; f < 8; f++) begin
            i32.in_valid = 1; i32.instr = mk(7'b0000001, 3'(f), 7'b0110011); i32.tag = 4'(f);
            step();
            chk($sformatf("t3_flags_f3_%0d", f),
                {59'd0, i32.signed_a, i32.signed_b, i32.upper_rem, i32.mul_valid, i32.div_valid},
                64'(exp3[f]));
        end
        i32.in_valid = 0;
        step();
        chk("t3_drained", 64'(i32.count), 0);

        // 4: fill with mul blocked; div_ready must not dequeue a MUL head
        i32.mul_ready = 0; i32.div_ready = 1;
        i32.in_valid = 1; i32.instr = 32'h02208033; i32.rs1 = 10; i32.tag = 1;
        step();
        i32.rs1 = 11; i32.tag = 2;
        step();
        chk("t4_full_count", 64'(i32.count), 2);
        chk("t4_full_ready", 64'(i32.in_ready), 0);
        chk("t4_head_tag", 64'(i32.head_tag), 1);
        i32.rs1 = 12; i32.tag = 3;
        step();
        i32.in_valid = 0;
        chk("t4_hold_count", 64'(i32.count), 2);
        chk("t4_hold_tag", 64'(i32.head_tag), 1);
        chk("t4_hold_op_a", 64'(i32.op_a), 10);
        i32.mul_ready = 1;
        step();
        chk("t4_drain1_tag", 64'(i32.head_tag), 2);
        chk("t4_drain1_op_a", 64'(i32.op_a), 11);
        chk("t4_drain1_ready", 64'(i32.in_ready), 1);
        step();
        chk("t4_empty", 64'(i32.count), 0);
        i32.mul_ready = 0; i32.div_ready = 0;

        // 5: simultaneous push/pop at occupancy 1
        i32.in_valid = 1; i32.tag = 0;
        step();
        chk("t5_prefill", 64'(i32.count), 1);
        i32.mul_ready = 1;
        for (int i = 0; i < 20; i++) begin
            i32.tag = 4'(i + 1);
            step();
            chk($sformatf("t5_count_%0d", i), 64'(i32.count), 1);
            chk($sformatf("t5_tag_%0d", i), 64'(i32.head_tag), 64'((i + 1) % 16));
        end
        i32.in_valid = 0;
        step();
        chk("t5_drained", 64'(i32.count), 0);
        i32.mul_ready = 0;

        // 6: RV64 W-ops and flush
        i64.in_valid = 1; i64.instr = mk(7'b0000001, 3'b100, 7'b0111011);
        i64.rs1 = 64'h0000_0000_8000_0000; i64.rs2 = 64'hFFFF_FFFF_0000_0003; i64.tag = 4;
        step();
        chk("t6_divw_op_a", i64.op_a, 64'hFFFF_FFFF_8000_0000);
        chk("t6_divw_op_b", i64.op_b, 64'h0000_0000_0000_0003);
        chk("t6_divw_word", 64'(i64.word), 1);
        chk("t6_divw_valids", {62'd0, i64.mul_valid, i64.div_valid}, 1);
        i64.instr = mk(7'b0000001, 3'b101, 7'b0111011); i64.tag = 5;
        step();
        i64.in_valid = 0;
        chk("t6_count2", 64'(i64.count), 2);
        i64.div_ready = 1;
        step();
        i64.div_ready = 0;
        chk("t6_divuw_tag", 64'(i64.head_tag), 5);
        chk("t6_divuw_op_a", i64.op_a, 64'h0000_0000_8000_0000);
        chk("t6_count1", 64'(i64.count), 1);
        i64.in_valid = 1; i64.instr = mk(7'b0000001, 3'b001, 7'b0111011); i64.tag = 6;
        step();
        chk("t6_mulhw_illegal", 64'(i64.illegal), 1);
        chk("t6_mulhw_tag", 64'(i64.illegal_tag), 6);
        i64.instr = mk(7'b0000001, 3'b000, 7'b0111011); i64.tag = 7;
        flush = 1;
        step();
        flush = 0; i64.in_valid = 0;
        chk("t6_flush_count", 64'(i64.count), 0);
        chk("t6_flush_valids", {61'd0, i64.illegal, i64.mul_valid, i64.div_valid}, 0);
        step();
        chk("t6_flush_discard", 64'(i64.count), 0);
        i64.in_valid = 1; i64.rs1 = 64'h1234_5678_8000_0001; i64.tag = 8;
        step();
        i64.in_valid = 0;
        chk("t6_mulw_valid", 64'(i64.mul_valid), 1);
        chk("t6_mulw_op_a", i64.op_a, 64'h0000_0000_8000_0001);
        chk("t6_mulw_illegal", 64'(i64.illegal), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
